// File: rtl/valu_pkg.sv
// Shared types and element-wise helpers for the pipelined vector-lane ALU.
// Contents: microop/SEW enums, per-stage control payload, legality/immediate
// decode, and elem_op which evaluates one 32-bit word element-wise at a given SEW.
package valu_pkg;

   localparam int unsigned UOP_W  = 5;
   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      SZ_8  = 2'b00,
      SZ_16 = 2'b01,
      SZ_32 = 2'b10
   } sew_e;

   typedef enum logic [UOP_W-1:0] {
      UOP_VADD    = 5'b00001,
      UOP_VSUB    = 5'b00010,
      UOP_VAND    = 5'b00011,
      UOP_VOR     = 5'b00100,
      UOP_VXOR    = 5'b00101,
      UOP_VSLL    = 5'b00110,
      UOP_VSRL    = 5'b00111,
      UOP_VSRA    = 5'b01000,
      UOP_VSLT    = 5'b01001,
      UOP_VSLTU   = 5'b01010,
      UOP_VMV_X_S = 5'b01011,
      UOP_VADDI   = 5'b10001,
      UOP_VANDI   = 5'b10011,
      UOP_VORI    = 5'b10100,
      UOP_VXORI   = 5'b10101,
      UOP_VSLLI   = 5'b10110,
      UOP_VSRLI   = 5'b10111,
      UOP_VSRAI   = 5'b11000,
      UOP_VMV_V_X = 5'b11001,
      UOP_VMACC   = 5'b11010
   } microop_e;

   // Control half of a stage payload; the width-parametric data fields
   // (result, c, mask) travel in parallel registers next to it.
   typedef struct packed {
      logic valid;
      logic is_mac;
      logic wren_scalar;
      logic illegal;
      sew_e sew;
   } stage_ctl_t;

   function automatic logic uop_legal(logic [UOP_W-1:0] op);
      return (op inside {5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                         5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010,
                         5'b01011, 5'b10001, [5'b10011:5'b11000],
                         5'b11001, 5'b11010});
   endfunction

   // Immediate forms are the register form plus 16 with imm replacing b.
   function automatic logic uop_is_imm(logic [UOP_W-1:0] op);
      return (op inside {5'b10001, [5'b10011:5'b11000]});
   endfunction

   // One element evaluated on 32-bit extended operands; caller keeps the low SEW bits.
   function automatic logic [WORD_W-1:0] lane_op(microop_e op, logic [4:0] sh_mask,
                                                 logic [WORD_W-1:0] ua, logic [WORD_W-1:0] ub,
                                                 logic [WORD_W-1:0] sa, logic [WORD_W-1:0] sb);
      logic [4:0]        shamt;
      logic [WORD_W-1:0] r;
      shamt = ub[4:0] & sh_mask;
      r     = '0;
      case (op)
         UOP_VADD:    r = ua + ub;
         UOP_VSUB:    r = ub - ua;
         UOP_VAND:    r = ua & ub;
         UOP_VOR:     r = ua | ub;
         UOP_VXOR:    r = ua ^ ub;
         UOP_VSLL:    r = ua << shamt;
         UOP_VSRL:    r = ua >> shamt;
         UOP_VSRA:    r = WORD_W'($signed(sa) >>> shamt);
         UOP_VSLT:    r = {31'b0, ($signed(sa) < $signed(sb))};
         UOP_VSLTU:   r = {31'b0, (ua < ub)};
         UOP_VMV_X_S: r = ua;
         UOP_VMV_V_X: r = ub;
         default:     r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [WORD_W-1:0] elem_op(microop_e op, sew_e sew,
                                                 logic [WORD_W-1:0] a, logic [WORD_W-1:0] b);
      logic [WORD_W-1:0] r;
      r = '0;
      case (sew)
         SZ_8: begin
            for (int unsigned e = 0; e < 4; e++)
               r[8*e +: 8] = 8'(lane_op(op, 5'h07,
                                        {24'b0, a[8*e +: 8]}, {24'b0, b[8*e +: 8]},
                                        {{24{a[8*e+7]}}, a[8*e +: 8]},
                                        {{24{b[8*e+7]}}, b[8*e +: 8]}));
         end
         SZ_16: begin
            for (int unsigned e = 0; e < 2; e++)
               r[16*e +: 16] = 16'(lane_op(op, 5'h0F,
                                           {16'b0, a[16*e +: 16]}, {16'b0, b[16*e +: 16]},
                                           {{16{a[16*e+15]}}, a[16*e +: 16]},
                                           {{16{b[16*e+15]}}, b[16*e +: 16]}));
         end
         default: r = lane_op(op, 5'h1F, a, b, a, b);
      endcase
      return r;
   endfunction

endpackage

// File: rtl/valu_if.sv
// Issue-side and writeback-side bus of the vector-lane ALU.
// slave modport: the ALU (consumes op + ready_i, produces ready_o + result).
// master modport: issue/writeback side.
interface valu_if #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned MICROOP_WIDTH = 5
);
   logic                     valid_i;
   logic                     ready_o;
   logic [MICROOP_WIDTH-1:0] microop_i;
   logic [1:0]               vsew_i;
   logic [DATA_WIDTH-1:0]    data_a_i;
   logic [DATA_WIDTH-1:0]    data_b_i;
   logic [DATA_WIDTH-1:0]    data_c_i;
   logic [DATA_WIDTH-1:0]    imm_i;
   logic [DATA_WIDTH/8-1:0]  mask_i;
   logic                     flush_i;
   logic                     valid_o;
   logic                     ready_i;
   logic [DATA_WIDTH-1:0]    result_o;
   logic                     wren_scalar_o;
   logic                     illegal_o;

   modport slave (
      input  valid_i, microop_i, vsew_i, data_a_i, data_b_i, data_c_i, imm_i, mask_i,
             flush_i, ready_i,
      output ready_o, valid_o, result_o, wren_scalar_o, illegal_o
   );

   modport master (
      output valid_i, microop_i, vsew_i, data_a_i, data_b_i, data_c_i, imm_i, mask_i,
             flush_i, ready_i,
      input  ready_o, valid_o, result_o, wren_scalar_o, illegal_o
   );
endinterface

// File: rtl/valu_mac_pipe.sv
// SEW-segmented multiply-accumulate pipe.
// Ports: clk, rst_n (sync, active-low), en_i (pipeline advance), sew_i/a_i/b_i
// (operands entering with the op), acc_i (accumulator aligned with the last
// stage), mac_o (acc + a*b per element, low SEW bits, combinational from last stage).
module valu_mac_pipe import valu_pkg::*; #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MUL_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en_i,
   input  sew_e                  sew_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic [DATA_WIDTH-1:0] acc_i,
   output logic [DATA_WIDTH-1:0] mac_o
);
   localparam int unsigned WORDS = DATA_WIDTH / WORD_W;
   localparam int unsigned LAST  = MUL_STAGES - 1;

   logic [DATA_WIDTH-1:0] prod_d;
   logic [DATA_WIDTH-1:0] prod_q [MUL_STAGES];
   sew_e                  sew_q  [MUL_STAGES];

   // Low-half products per element; carries never cross element boundaries.
   always_comb begin
      prod_d = '0;
      for (int unsigned w = 0; w < WORDS; w++) begin
         case (sew_i)
            SZ_8:
               for (int unsigned e = 0; e < 4; e++)
                  prod_d[32*w+8*e +: 8] = a_i[32*w+8*e +: 8] * b_i[32*w+8*e +: 8];
            SZ_16:
               for (int unsigned e = 0; e < 2; e++)
                  prod_d[32*w+16*e +: 16] = a_i[32*w+16*e +: 16] * b_i[32*w+16*e +: 16];
            default:
               prod_d[32*w +: 32] = a_i[32*w +: 32] * b_i[32*w +: 32];
         endcase
      end
   end

   // Product delay line; frozen together with the main pipe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < MUL_STAGES; k++) begin
            prod_q[k] <= '0;
            sew_q[k]  <= SZ_8;
         end
      end else if (en_i) begin
         prod_q[0] <= prod_d;
         sew_q[0]  <= sew_i;
         for (int unsigned k = 1; k < MUL_STAGES; k++) begin
            prod_q[k] <= prod_q[k-1];
            sew_q[k]  <= sew_q[k-1];
         end
      end
   end

   // Segmented accumulate at the element width the op was issued with.
   always_comb begin
      mac_o = '0;
      for (int unsigned w = 0; w < WORDS; w++) begin
         case (sew_q[LAST])
            SZ_8:
               for (int unsigned e = 0; e < 4; e++)
                  mac_o[32*w+8*e +: 8] = prod_q[LAST][32*w+8*e +: 8] + acc_i[32*w+8*e +: 8];
            SZ_16:
               for (int unsigned e = 0; e < 2; e++)
                  mac_o[32*w+16*e +: 16] = prod_q[LAST][32*w+16*e +: 16] + acc_i[32*w+16*e +: 16];
            default:
               mac_o[32*w +: 32] = prod_q[LAST][32*w +: 32] + acc_i[32*w +: 32];
         endcase
      end
   end

endmodule

// File: rtl/valu_pipe.sv
// Pipelined vector-lane integer ALU, fixed latency 1 + MUL_STAGES.
// Ports: clk, rst_n (sync, active-low), alu_if (valu_if.slave: op/operands/mask,
// flush_i, valid/ready handshake on both sides, result_o, wren_scalar_o, illegal_o).
// Simple ops finish in stage 1 and ride delay stages; VMACC finishes in the
// output stage from valu_mac_pipe. Every stage freezes while the output stalls.
module valu_pipe import valu_pkg::*; #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned MICROOP_WIDTH = 5,
   parameter int unsigned MUL_STAGES    = 2
) (
   input  logic   clk,
   input  logic   rst_n,
   valu_if.slave  alu_if
);
   localparam int unsigned MASK_W = DATA_WIDTH / 8;
   localparam int unsigned WORDS  = DATA_WIDTH / WORD_W;
   localparam int unsigned LAST   = MUL_STAGES - 1;

   // Inactive elements (lowest byte mask bit clear) keep the old vd value.
   function automatic logic [DATA_WIDTH-1:0] mask_merge(logic [DATA_WIDTH-1:0] res,
                                                        logic [DATA_WIDTH-1:0] c,
                                                        logic [MASK_W-1:0]     m,
                                                        sew_e                  sew);
      logic [DATA_WIDTH-1:0] r;
      r = c;
      case (sew)
         SZ_8:
            for (int unsigned e = 0; e < MASK_W; e++)
               if (m[e]) r[8*e +: 8] = res[8*e +: 8];
         SZ_16:
            for (int unsigned e = 0; e < MASK_W/2; e++)
               if (m[2*e]) r[16*e +: 16] = res[16*e +: 16];
         default:
            for (int unsigned e = 0; e < MASK_W/4; e++)
               if (m[4*e]) r[32*e +: 32] = res[32*e +: 32];
      endcase
      return r;
   endfunction

   logic                  advance;
   logic [UOP_W-1:0]      op_lo;
   logic                  op_legal;
   logic                  op_imm;
   microop_e              base_op;
   sew_e                  sew_in;
   logic [DATA_WIDTH-1:0] eff_b;
   logic [DATA_WIDTH-1:0] raw_res;
   logic [DATA_WIDTH-1:0] mac_res;
   stage_ctl_t            s0_ctl_d;
   logic [DATA_WIDTH-1:0] s0_res_d;
   logic [DATA_WIDTH-1:0] out_res_d;

   stage_ctl_t            mid_ctl_q  [MUL_STAGES];
   logic [DATA_WIDTH-1:0] mid_res_q  [MUL_STAGES];
   logic [DATA_WIDTH-1:0] mid_c_q    [MUL_STAGES];
   logic [MASK_W-1:0]     mid_mask_q [MUL_STAGES];

   logic                  out_valid_q;
   logic                  out_wren_q;
   logic                  out_ill_q;
   logic [DATA_WIDTH-1:0] out_res_q;

   // The whole pipe moves as one; a held output freezes every stage.
   assign advance        = ~out_valid_q | alu_if.ready_i;
   assign alu_if.ready_o = advance;
   assign sew_in         = sew_e'(alu_if.vsew_i);

   // Stage-1 decode and simple-op evaluation.
   always_comb begin
      op_lo    = alu_if.microop_i[UOP_W-1:0];
      op_legal = uop_legal(op_lo) && (alu_if.vsew_i != 2'b11) &&
                 ((alu_if.microop_i >> UOP_W) == '0);
      op_imm   = uop_is_imm(op_lo);
      base_op  = op_imm ? microop_e'(UOP_W'(op_lo - 5'd16)) : microop_e'(op_lo);
      eff_b    = op_imm ? alu_if.imm_i : alu_if.data_b_i;
      raw_res  = '0;
      for (int unsigned w = 0; w < WORDS; w++)
         raw_res[32*w +: 32] = elem_op(base_op, sew_in, alu_if.data_a_i[32*w +: 32],
                                       eff_b[32*w +: 32]);

      s0_ctl_d.valid       = alu_if.valid_i;
      s0_ctl_d.is_mac      = op_legal && (op_lo == UOP_VMACC);
      s0_ctl_d.wren_scalar = op_legal && (op_lo == UOP_VMV_X_S);
      s0_ctl_d.illegal     = ~op_legal;
      s0_ctl_d.sew         = sew_in;

      if (!op_legal || s0_ctl_d.is_mac)
         s0_res_d = '0;
      else if (s0_ctl_d.wren_scalar)
         s0_res_d = raw_res;
      else
         s0_res_d = mask_merge(raw_res, alu_if.data_c_i, alu_if.mask_i, sew_in);
   end

   valu_mac_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .MUL_STAGES (MUL_STAGES)
   ) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (advance),
      .sew_i (sew_in),
      .a_i   (alu_if.data_a_i),
      .b_i   (alu_if.data_b_i),
      .acc_i (mid_c_q[LAST]),
      .mac_o (mac_res)
   );

   // Output-stage select: VMACC completes here, everything else is already done.
   always_comb begin
      out_res_d = mid_res_q[LAST];
      if (mid_ctl_q[LAST].is_mac)
         out_res_d = mask_merge(mac_res, mid_c_q[LAST], mid_mask_q[LAST], mid_ctl_q[LAST].sew);
   end

   // Stage registers; flush drops in-flight ops and any same-cycle transfer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < MUL_STAGES; k++) begin
            mid_ctl_q[k]  <= '0;
            mid_res_q[k]  <= '0;
            mid_c_q[k]    <= '0;
            mid_mask_q[k] <= '0;
         end
         out_valid_q <= 1'b0;
         out_wren_q  <= 1'b0;
         out_ill_q   <= 1'b0;
         out_res_q   <= '0;
      end else if (alu_if.flush_i) begin
         for (int unsigned k = 0; k < MUL_STAGES; k++)
            mid_ctl_q[k].valid <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (advance) begin
         mid_ctl_q[0]  <= s0_ctl_d;
         mid_res_q[0]  <= s0_res_d;
         mid_c_q[0]    <= alu_if.data_c_i;
         mid_mask_q[0] <= alu_if.mask_i;
         for (int unsigned k = 1; k < MUL_STAGES; k++) begin
            mid_ctl_q[k]  <= mid_ctl_q[k-1];
            mid_res_q[k]  <= mid_res_q[k-1];
            mid_c_q[k]    <= mid_c_q[k-1];
            mid_mask_q[k] <= mid_mask_q[k-1];
         end
         out_valid_q <= mid_ctl_q[LAST].valid;
         out_wren_q  <= mid_ctl_q[LAST].valid & mid_ctl_q[LAST].wren_scalar;
         out_ill_q   <= mid_ctl_q[LAST].valid & mid_ctl_q[LAST].illegal;
         out_res_q   <= out_res_d;
      end
   end

   assign alu_if.valid_o       = out_valid_q;
   assign alu_if.result_o      = out_res_q;
   assign alu_if.wren_scalar_o = out_wren_q;
   assign alu_if.illegal_o     = out_ill_q;

endmodule

// File: tb/tb_valu_pipe.sv
// Directed bench for valu_pipe (DATA_WIDTH=32, MUL_STAGES=2, latency 3).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_valu_pipe;
   import valu_pkg::*;

   localparam int unsigned DW  = 32;
   localparam int unsigned MS  = 2;
   localparam int unsigned LAT = 1 + MS;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   valu_if #(.DATA_WIDTH(DW), .MICROOP_WIDTH(5)) vif ();

   valu_pipe #(
      .DATA_WIDTH    (DW),
      .MICROOP_WIDTH (5),
      .MUL_STAGES    (MS)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .alu_if (vif)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [4:0] op, input logic [1:0] sew, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input logic [31:0] imm,
                        input logic [3:0] m);
      vif.valid_i   = 1'b1;
      vif.microop_i = op;
      vif.vsew_i    = sew;
      vif.data_a_i  = a;
      vif.data_b_i  = b;
      vif.data_c_i  = c;
      vif.imm_i     = imm;
      vif.mask_i    = m;
   endtask

   // One isolated op: no early valid_o, then the expected result exactly LAT edges later.
   task automatic run_op(input string tag, input logic [4:0] op, input logic [1:0] sew,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] imm, input logic [3:0] m,
                         input logic [31:0] exp_res, input logic exp_wren, input logic exp_ill);
      @(negedge clk);
      drive(op, sew, a, b, c, imm, m);
      for (int i = 1; i < int'(LAT); i++) begin
         @(negedge clk);
         vif.valid_i = 1'b0;
         check_eq({tag, "_early_valid"}, 64'(vif.valid_o), 64'd0);
      end
      @(negedge clk);
      check_eq({tag, "_valid"}, 64'(vif.valid_o), 64'd1);
      check_eq({tag, "_result"}, 64'(vif.result_o), 64'(exp_res));
      check_eq({tag, "_wren"}, 64'(vif.wren_scalar_o), 64'(exp_wren));
      check_eq({tag, "_illegal"}, 64'(vif.illegal_o), 64'(exp_ill));
   endtask

   initial begin
      int sent;
      int got;

      rst_n         = 1'b0;
      vif.flush_i   = 1'b0;
      vif.ready_i   = 1'b0;
      drive(UOP_VADD, 2'b10, 32'h1, 32'h2, 32'h0, 32'h0, 4'hF);

      // Reset held 3 cycles with valid_i high.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("rst_valid", 64'(vif.valid_o), 64'd0);
         check_eq("rst_result", 64'(vif.result_o), 64'd0);
      end
      rst_n       = 1'b1;
      vif.valid_i = 1'b0;
      #1;
      check_eq("rst_ready", 64'(vif.ready_o), 64'd1);
      vif.ready_i = 1'b1;

      run_op("vadd8", UOP_VADD, 2'b00, 32'h01FF_7F80, 32'h0101_0180, 32'h0, 32'h0, 4'hF,
             32'h0200_8000, 1'b0, 1'b0);
      run_op("vmacc16", UOP_VMACC, 2'b01, 32'h0003_FFFF, 32'h0004_0002, 32'h0001_0001, 32'h0,
             4'b0011, 32'h0001_FFFF, 1'b0, 1'b0);
      run_op("vmacc8", UOP_VMACC, 2'b00, 32'h0203_0405, 32'h1010_1010, 32'h0101_0101, 32'h0,
             4'hF, 32'h2131_4151, 1'b0, 1'b0);
      run_op("vmacc32", UOP_VMACC, 2'b10, 32'h0001_0000, 32'h0001_0000, 32'h5, 32'h0,
             4'hF, 32'h5, 1'b0, 1'b0);
      run_op("vsub32", UOP_VSUB, 2'b10, 32'h5, 32'h3, 32'h0, 32'h0, 4'hF,
             32'hFFFF_FFFE, 1'b0, 1'b0);
      run_op("vsra8", UOP_VSRA, 2'b00, 32'h8040_F07F, 32'h0102_0409, 32'h0, 32'h0, 4'hF,
             32'hC010_FF3F, 1'b0, 1'b0);
      run_op("vslt16", UOP_VSLT, 2'b01, 32'hFFFF_0001, 32'h0000_0001, 32'h0, 32'h0, 4'hF,
             32'h0001_0000, 1'b0, 1'b0);
      run_op("vsltu16", UOP_VSLTU, 2'b01, 32'hFFFF_0001, 32'h0000_0002, 32'h0, 32'h0, 4'hF,
             32'h0000_0001, 1'b0, 1'b0);
      run_op("vsll16", UOP_VSLL, 2'b01, 32'h0001_8001, 32'h0011_0004, 32'h0, 32'h0, 4'hF,
             32'h0002_0010, 1'b0, 1'b0);
      run_op("vxori32", UOP_VXORI, 2'b10, 32'hF0F0_F0F0, 32'h1234_5678, 32'h0, 32'hFFFF_0000,
             4'hF, 32'h0F0F_F0F0, 1'b0, 1'b0);
      run_op("vadd8_mask", UOP_VADD, 2'b00, 32'h0101_0101, 32'h0101_0101, 32'hAABB_CCDD, 32'h0,
             4'b0101, 32'hAA02_CC02, 1'b0, 1'b0);
      run_op("illegal_op", 5'b11111, 2'b10, 32'h1234_5678, 32'h1, 32'hFFFF_FFFF, 32'h0, 4'hF,
             32'h0, 1'b0, 1'b1);
      run_op("illegal_sew", UOP_VADD, 2'b11, 32'h1, 32'h1, 32'hFFFF_FFFF, 32'h0, 4'hF,
             32'h0, 1'b0, 1'b1);
      run_op("vmv_x_s", UOP_VMV_X_S, 2'b10, 32'hDEAD_BEEF, 32'h0, 32'h1111_1111, 32'h0, 4'h0,
             32'hDEAD_BEEF, 1'b1, 1'b0);
      run_op("vmv_v_x", UOP_VMV_V_X, 2'b10, 32'h0, 32'hCAFE_F00D, 32'h0, 32'h0, 4'hF,
             32'hCAFE_F00D, 1'b0, 1'b0);

      // Back-to-back stream of 8 ops with writeback stalled in cycles 3-5.
      @(negedge clk);
      vif.valid_i = 1'b0;
      sent = 0;
      got  = 0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         @(negedge clk);
         if (vif.valid_o)
            check_eq("stream_result", 64'(vif.result_o), 64'(100 + got));
         vif.ready_i = !(cyc >= 3 && cyc <= 5);
         if (sent < 8)
            drive(UOP_VADD, 2'b10, 32'(sent), 32'd100, 32'h0, 32'h0, 4'hF);
         else
            vif.valid_i = 1'b0;
         #1;
         if (vif.valid_o && !vif.ready_i)
            check_eq("stream_stall_ready", 64'(vif.ready_o), 64'd0);
         if (vif.valid_o && vif.ready_i)
            got++;
         if (vif.valid_i && vif.ready_o)
            sent++;
      end
      vif.valid_i = 1'b0;
      vif.ready_i = 1'b1;
      check_eq("stream_got", 64'(got), 64'd8);
      check_eq("stream_sent", 64'(sent), 64'd8);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_eq("stream_no_dup", 64'(vif.valid_o), 64'd0);
      end

      // Flush with two ops in flight and a third transferring the same cycle.
      @(negedge clk);
      drive(UOP_VADD, 2'b10, 32'h1, 32'h1, 32'h0, 32'h0, 4'hF);
      @(negedge clk);
      drive(UOP_VADD, 2'b10, 32'h2, 32'h2, 32'h0, 32'h0, 4'hF);
      @(negedge clk);
      drive(UOP_VADD, 2'b10, 32'h3, 32'h3, 32'h0, 32'h0, 4'hF);
      vif.flush_i = 1'b1;
      @(negedge clk);
      vif.flush_i = 1'b0;
      vif.valid_i = 1'b0;
      for (int i = 0; i < int'(LAT) + 1; i++) begin
         check_eq("flush_no_valid", 64'(vif.valid_o), 64'd0);
         @(negedge clk);
      end
      run_op("after_flush", UOP_VOR, 2'b10, 32'hF000_000F, 32'h0F00_00F0, 32'h0, 32'h0, 4'hF,
             32'hFF00_00FF, 1'b0, 1'b0);

      // Reset with an op in flight drops it.
      @(negedge clk);
      drive(UOP_VADD, 2'b10, 32'h7, 32'h7, 32'h0, 32'h0, 4'hF);
      @(negedge clk);
      vif.valid_i = 1'b0;
      rst_n       = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < int'(LAT); i++) begin
         check_eq("rst_mid_no_valid", 64'(vif.valid_o), 64'd0);
         @(negedge clk);
      end
      run_op("after_rst", UOP_VAND, 2'b10, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0, 32'h0, 4'hF,
             32'h0F0F_0000, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
